vram_arbiter: RTL

- Arbitrates one single-port, synchronous-read video RAM between two requesters.
- Requester 1 is the VGA scan-out reader, which has fixed priority.
- Requester 2 is the schoolMIPS CPU bus, using a req/ack handshake.
- Sits between the sm_top CPU data bus, the racing-game pixel generator and the VRAM macro. A starvation guard forces one CPU slot when the CPU has waited too long, and counts the resulting video misses.

---
 rtl/vram_arb_pkg.sv | 26 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/vram_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared types for the VRAM arbiter:
//   arb_state_e : CPU handshake FSM states
//   gnt_e       : per-cycle RAM grant (nobody / video scan-out / CPU)
//   cnt_w()     : bits needed to hold a counter that tops out at max_val
// ---------------------------------------------------------------------------
package vram_arb_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CPU_RESP = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_e;

    // A limit of 0 or 1 still needs one bit of storage.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at MAX instead of wrapping. clr has priority over
// inc. Synchronous active-low reset.
//   clk    : clock
//   rst_n  : synchronous active-low reset (clears the count)
//   inc_i  : count up by one this cycle (ignored at MAX)
//   clr_i  : return to zero this cycle
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port, synchronous-read VRAM between the VGA scan-out
// reader (fixed priority, one read per cycle) and the schoolMIPS CPU bus
// (req/ack handshake, one access per two cycles at best). When the CPU has
// been held off for STARVE_LIMIT cycles it is given one forced slot and the
// displaced video read is reported as a miss.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   vid_req/vid_addr    : scan-out read request for this cycle
//   vid_rvalid          : previous cycle's video request was served
//   vid_rdata           : RAM read data (straight from ram_rdata)
//   vid_miss            : previous cycle's video request was denied
//   miss_cnt            : saturating count of denied video requests
//   cpu_req/we/addr/wdata : CPU access, held stable until cpu_ack
//   cpu_ack             : one-cycle completion pulse (cycle after grant)
//   cpu_rdata           : read data, valid with cpu_ack and held afterwards
//   ram_en/we/addr/wdata: RAM port, combinational from this cycle's grant
//   ram_rdata           : RAM read data, one cycle after ram_en
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 15,
    parameter int MISS_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_miss,
    output logic [MISS_W-1:0] miss_cnt,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                WAIT_W   = cnt_w(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    arb_state_e        state_q;
    arb_state_e        state_d;
    gnt_e              gnt;

    logic [WAIT_W-1:0] wait_cnt;
    logic              starve;
    logic              cpu_elig;     // CPU may be granted this cycle
    logic              vid_denied;
    logic              wait_inc;
    logic              wait_clr;

    logic              acc_we_q;     // direction of the CPU access in flight
    logic              rdata_ld;     // ack cycle of a CPU read
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic              vid_rvalid_q;
    logic              vid_miss_q;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    assign starve   = (STARVE_LIMIT != 0) && (wait_cnt == WAIT_MAX);
    // A request still high during CPU_RESP is the one being acked, so it
    // must not be granted a second time.
    assign cpu_elig = cpu_req && (state_q == IDLE);

    always_comb begin
        gnt = GNT_NONE;
        if (vid_req && !(starve && cpu_elig)) begin
            gnt = GNT_VID;
        end else if (cpu_elig) begin
            gnt = GNT_CPU;
        end
    end

    assign vid_denied = vid_req && (gnt != GNT_VID);

    // ------------------------------------------------------------------
    // RAM port; enables are held low while reset is asserted
    // ------------------------------------------------------------------
    assign ram_en    = rst_n && (gnt != GNT_NONE);
    assign ram_we    = rst_n && (gnt == GNT_CPU) && cpu_we;
    assign ram_addr  = (gnt == GNT_CPU) ? cpu_addr : vid_addr;
    assign ram_wdata = cpu_wdata;

    // ------------------------------------------------------------------
    // CPU handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (gnt == GNT_CPU) state_d = CPU_RESP;
            CPU_RESP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Ack is gated by rst_n so an access interrupted by reset never acks.
    always_comb begin
        cpu_ack  = 1'b0;
        rdata_ld = 1'b0;
        if (rst_n && (state_q == CPU_RESP)) begin
            cpu_ack  = 1'b1;
            rdata_ld = !acc_we_q;
        end
    end

    // Read data is visible in the ack cycle itself, then held.
    assign cpu_rdata_d = rdata_ld ? ram_rdata : cpu_rdata_q;

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_we_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_miss_q   <= 1'b0;
        end else begin
            if (gnt == GNT_CPU) acc_we_q <= cpu_we;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rvalid_q <= (gnt == GNT_VID);
            vid_miss_q   <= vid_denied;
        end
    end

    assign cpu_rdata  = cpu_rdata_d;
    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = ram_rdata;
    assign vid_miss   = vid_miss_q;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    // Waiting only counts while the CPU is eligible and losing; a dropped
    // request is a withdrawal and restarts the wait from zero.
    assign wait_inc = cpu_elig && (gnt != GNT_CPU);
    assign wait_clr = (gnt == GNT_CPU) || !cpu_req;

    sat_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .cnt_o (wait_cnt)
    );

    sat_counter #(
        .W   (MISS_W),
        .MAX ({MISS_W{1'b1}})
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (vid_denied),
        .clr_i (1'b0),
        .cnt_o (miss_cnt)
    );

endmodule
